// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder.
// Used by cla_seq_add_ctrl and its 7-bit slice.
package cla_seq_pkg;

  localparam int SLICE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter width; a single-slice configuration still needs one bit.
  function automatic int idx_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/cla_seq_add_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_add_ctrl.
// master = requester/consumer side, slave = the adder.
interface cla_seq_add_ctrl_if #(
  parameter int WIDTH = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_seq_add_ctrl_cla7_slice.sv
// Combinational 7-bit carry-lookahead slice: every carry is a flat
// sum of generate/propagate products, no ripple between bit positions.
module cla7_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a7,
  input  logic [SLICE_W-1:0] b7,
  input  logic               ci,
  output logic [SLICE_W-1:0] s7,
  output logic               co
);
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  assign p = a7 ^ b7;
  assign g = a7 & b7;

  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end

  assign s7 = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];
endmodule

// File: rtl/cla_seq_add_ctrl.sv
// WIDTH-bit add/subtract stepped through one 7-bit CLA slice per cycle.
// Optional macro CLA_SEQ_EARLY_EXIT_EN: finish early once the carry and all higher operand bits are zero.
module cla_seq_add_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_seq_add_ctrl_if.slave bus,
  output logic              busy
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
    $error("cla_seq_add_ctrl: WIDTH must be a positive multiple of 7");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  int               base;
  logic [SLICE_W-1:0] a7, b7, s7;
  logic             co;

  assign base = SLICE_W * int'(idx_q);
  assign a7   = a_q[base +: SLICE_W];
  assign b7   = b_q[base +: SLICE_W];

  cla7_slice u_slice (
    .a7 (a7),
    .b7 (b7),
    .ci (carry_q),
    .s7 (s7),
    .co (co)
  );

`ifdef CLA_SEQ_EARLY_EXIT_EN
  logic hi_zero;
  assign hi_zero = ((a_q | b_q) >> (base + SLICE_W)) == '0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[base +: SLICE_W] = s7;
        carry_d                = co;
        // The counter parks on the last slice instead of wrapping.
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          cout_d  = co;
          state_d = ST_DONE;
        end
`ifdef CLA_SEQ_EARLY_EXIT_EN
        else if (!co && hi_zero) begin
          cout_d  = 1'b0;
          state_d = ST_DONE;
        end
`endif
        else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed-vector bench for cla_seq_add_ctrl at WIDTH=28.
// Expected latency follows CLA_SEQ_EARLY_EXIT_EN when it is defined.
module tb_cla_seq_add_ctrl;
  localparam int WIDTH = 28;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_errors;

  cla_seq_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cycles from accept to out_valid, worked out slice by slice on the operands.
  function automatic int exp_lat(input logic [27:0] a, input logic [27:0] be, input logic c);
`ifdef CLA_SEQ_EARLY_EXIT_EN
    logic [7:0] s;
    logic       cc;
    cc = c;
    for (int i = 0; i < 4; i++) begin
      s  = {1'b0, a[7*i +: 7]} + {1'b0, be[7*i +: 7]} + {7'd0, cc};
      cc = s[7];
      if (!cc && (((a | be) >> (7 * (i + 1))) == 28'd0)) return i + 1;
    end
`else
    if (a[0] === 1'bx || be[0] === 1'bx || c === 1'bx) return 0;
`endif
    return 4;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [27:0] a, input logic [27:0] b,
                       input logic ci, input logic sb,
                       input logic [27:0] exp_sum, input logic exp_cout);
    int lat;
    logic [27:0] be;
    be = sb ? ~b : b;
    chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.sub      = sb;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_in_ready_run"}, bus.in_ready, 0);
    chk({tag, "_busy_run"}, busy, 1);
    wait_valid(lat);
    chk({tag, "_latency"}, lat, exp_lat(a, be, sb | ci));
    chk({tag, "_sum"}, bus.sum, exp_sum);
    chk({tag, "_cout"}, bus.cout, exp_cout);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_in_ready_back"}, bus.in_ready, 1);
    chk({tag, "_sum_held"}, bus.sum, exp_sum);
  endtask

  initial begin
    int lat;
    bit seen;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_1_1",   28'h0000001, 28'h0000001, 1'b0, 1'b0, 28'h0000002, 1'b0);
    do_op("add_wrap",  28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0, 28'h0000000, 1'b1);
    do_op("sub_neg",   28'h0000005, 28'h0000007, 1'b0, 1'b1, 28'hFFFFFFE, 1'b0);
    do_op("sub_pos",   28'h0000007, 28'h0000005, 1'b1, 1'b1, 28'h0000002, 1'b1);
    do_op("add_cin",   28'h1234567, 28'h7654321, 1'b1, 1'b0, 28'h8888889, 1'b0);
    do_op("early_3_4", 28'h0000003, 28'h0000004, 1'b0, 1'b0, 28'h0000007, 1'b0);

    // Backpressure: result held while a new request waits on in_valid.
    bus.a = 28'h0000010; bus.b = 28'h0000020; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 28'h0ABCDEF; bus.b = 28'h0123456;
    wait_valid(lat);
    chk("bp_reach_done", bus.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_sum", bus.sum, 28'h0000030);
      chk("bp_cout", bus.cout, 0);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_new_accept", bus.in_ready, 0);
    chk("bp_sum_cleared", bus.sum, 0);
    wait_valid(lat);
    chk("bp_new_latency", lat + 0, 4);
    chk("bp_new_sum", bus.sum, 28'h0BE0245);
    chk("bp_new_cout", bus.cout, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset while the third slice is being processed.
    bus.a = 28'hFFFFFFF; bus.b = 28'h0000001; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rr_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rr_out_valid", bus.out_valid, 0);
    chk("rr_in_ready", bus.in_ready, 1);
    chk("rr_sum", bus.sum, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cout", bus.cout, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rr_no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
